inputs_capture_module: RTL and testbench

//  - Input-side counterpart of the output buffer: snapshots the intercepted input bus on command.
//  - Keeps current and previous snapshots and serves single-bit reads by address to the edit engine.
//  - Reads can return the current or previous level, or a rising/falling edge between the two.
//  - Arms a mask/match trigger that fires when a captured snapshot matches a pattern.

---
 rtl/inputs_capture_module.sv | 161 ++++++++++++++++
 tb/tb_inputs_capture_module.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inputs_capture_module.sv
// Input-bus snapshot unit: current/previous capture, bit reads, mask/match trigger.
// Latency: capture and read results appear one cycle after the request edge.
// Backpressure: none, accepts a capture and a read every cycle.
// Optional INPUTS_SYNC_EN: passes in_data through a 2-flop synchroniser before capture.
module inputs_capture_module #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              en_capture,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        rd_sel,
   input  logic              arm,
   input  logic              disarm,
   input  logic [WIDTH-1:0]  trg_mask,
   input  logic [WIDTH-1:0]  trg_match,
   output logic              rd_val,
   output logic              rd_valid,
   output logic              captured,
   output logic              changed,
   output logic              trig,
   output logic [CNT_W-1:0]  cap_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRED = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] s_in;
   logic [WIDTH-1:0] cur_q;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] match_q;
   logic [WIDTH-1:0] eff_mask;
   logic [WIDTH-1:0] eff_match;
   logic [WIDTH-1:0] rd_src;
   logic             rd_bit;
   logic             hit;
   logic             load_trg;

`ifdef INPUTS_SYNC_EN
   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;

   // Two-flop synchroniser for asynchronous input sources
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= in_data;
         sync_q2 <= sync_q1;
      end
   end

   assign s_in = sync_q2;
`else
   assign s_in = in_data;
`endif

   // Snapshot registers, capture pulse, change flag and capture counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_q     <= '0;
         prev_q    <= '0;
         captured  <= 1'b0;
         changed   <= 1'b0;
         cap_count <= '0;
      end else begin
         captured <= en_capture;
         if (en_capture) begin
            prev_q    <= cur_q;
            cur_q     <= s_in;
            changed   <= |(s_in ^ cur_q);
            cap_count <= cap_count + CNT_W'(1);
         end
      end
   end

   // Read source selection; uses pre-capture cur/prev, out-of-range addresses read 0
   always_comb begin
      rd_src = cur_q;
      case (rd_sel)
         2'd0:    rd_src = cur_q;
         2'd1:    rd_src = prev_q;
         2'd2:    rd_src = ~prev_q & cur_q;
         default: rd_src = prev_q & ~cur_q;
      endcase
      rd_bit = 1'b0;
      if (32'(addr) < WIDTH)
         rd_bit = rd_src[addr];
   end

   // Registered read result; rd_val holds when no read is requested
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_val   <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en)
            rd_val <= rd_bit;
      end
   end

   // Trigger pattern registers; disarm suppresses a simultaneous load
   assign load_trg = arm & ~disarm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q  <= '0;
         match_q <= '0;
      end else if (load_trg) begin
         mask_q  <= trg_mask;
         match_q <= trg_match;
      end
   end

   // A capture in the arming cycle compares against the pattern being loaded
   assign eff_mask  = arm ? trg_mask  : mask_q;
   assign eff_match = arm ? trg_match : match_q;
   assign hit       = ((s_in ^ eff_match) & eff_mask) == '0;

   // Trigger FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Trigger FSM next state: disarm dominates, arm restarts from ARMED
   always_comb begin
      state_d = state_q;
      if (disarm) begin
         state_d = IDLE;
      end else if (arm) begin
         state_d = (en_capture && hit) ? FIRED : ARMED;
      end else begin
         case (state_q)
            ARMED:   if (en_capture && hit) state_d = FIRED;
            FIRED:   state_d = FIRED;
            default: state_d = IDLE;
         endcase
      end
   end

   // Trigger FSM output
   always_comb begin
      trig = (state_q == FIRED);
   end

endmodule

// File: tb/tb_inputs_capture_module.sv
// Directed bench for inputs_capture_module.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Every capture holds in_data for two cycles first so the synchronised build sees it.
module tb_inputs_capture_module;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;

   logic              clk;
   logic              reset;
   logic [WIDTH-1:0]  in_data;
   logic              en_capture;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        rd_sel;
   logic              arm;
   logic              disarm;
   logic [WIDTH-1:0]  trg_mask;
   logic [WIDTH-1:0]  trg_match;
   logic              rd_val;
   logic              rd_valid;
   logic              captured;
   logic              changed;
   logic              trig;
   logic [CNT_W-1:0]  cap_count;

   int tests;
   int fails;
   int exp_cnt;

   inputs_capture_module #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .en_capture(en_capture),
      .rd_en(rd_en), .addr(addr), .rd_sel(rd_sel), .arm(arm), .disarm(disarm),
      .trg_mask(trg_mask), .trg_match(trg_match), .rd_val(rd_val), .rd_valid(rd_valid),
      .captured(captured), .changed(changed), .trig(trig), .cap_count(cap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold value for two cycles, then capture it in a single cycle
   task automatic capture(input logic [WIDTH-1:0] v);
      in_data = v;
      tick();
      tick();
      en_capture = 1'b1;
      tick();
      en_capture = 1'b0;
      exp_cnt++;
   endtask

   task automatic read(input logic [ADDR_W-1:0] a, input logic [1:0] s);
      addr   = a;
      rd_sel = s;
      rd_en  = 1'b1;
      tick();
      rd_en  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests++; if ({rd_val, rd_valid, captured, changed, trig} !== 5'b0) begin
         fails++; $display("FAIL reset_flags: got %b expected 00000", {rd_val, rd_valid, captured, changed, trig});
      end
      tests++; if (cap_count !== 16'h0) begin
         fails++; $display("FAIL reset_count: got %h expected 0000", cap_count);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_capture();
      capture(32'hA5A5_0F0F);
      tests++; if (captured !== 1'b1) begin
         fails++; $display("FAIL cap1_captured: got %b expected 1", captured);
      end
      tests++; if (cap_count !== 16'd1) begin
         fails++; $display("FAIL cap1_count: got %h expected 0001", cap_count);
      end
      tests++; if (changed !== 1'b1) begin
         fails++; $display("FAIL cap1_changed: got %b expected 1", changed);
      end
      read(5'd0, 2'd0);
      tests++; if ({rd_val, rd_valid, captured} !== 3'b110) begin
         fails++; $display("FAIL rd_a0_cur: got %b expected 110", {rd_val, rd_valid, captured});
      end
      tick();
      tests++; if ({rd_val, rd_valid} !== 2'b10) begin
         fails++; $display("FAIL rd_hold: got %b expected 10", {rd_val, rd_valid});
      end
      read(5'd4, 2'd0);
      tests++; if ({rd_val, rd_valid} !== 2'b01) begin
         fails++; $display("FAIL rd_a4_cur: got %b expected 01", {rd_val, rd_valid});
      end
      read(5'd31, 2'd0);
      tests++; if (rd_val !== 1'b1) begin
         fails++; $display("FAIL rd_a31_cur: got %b expected 1", rd_val);
      end
   endtask

   task automatic test_edges();
      capture(32'h0000_0000);
      capture(32'h0000_0010);
      tests++; if (changed !== 1'b1) begin
         fails++; $display("FAIL edge_changed: got %b expected 1", changed);
      end
      read(5'd4, 2'd2);
      tests++; if (rd_val !== 1'b1) begin
         fails++; $display("FAIL edge_rise: got %b expected 1", rd_val);
      end
      read(5'd4, 2'd3);
      tests++; if (rd_val !== 1'b0) begin
         fails++; $display("FAIL edge_fall: got %b expected 0", rd_val);
      end
      read(5'd4, 2'd2);
      read(5'd4, 2'd1);
      tests++; if (rd_val !== 1'b0) begin
         fails++; $display("FAIL edge_prev: got %b expected 0", rd_val);
      end
      capture(32'h0000_0010);
      tests++; if ({captured, changed} !== 2'b10) begin
         fails++; $display("FAIL edge_unchanged: got %b expected 10", {captured, changed});
      end
      tests++; if (cap_count !== exp_cnt[15:0]) begin
         fails++; $display("FAIL edge_count: got %h expected %h", cap_count, exp_cnt[15:0]);
      end
   endtask

   task automatic test_read_during_capture();
      in_data = 32'h0;
      tick();
      tick();
      addr = 5'd4; rd_sel = 2'd0; rd_en = 1'b1; en_capture = 1'b1;
      tick();
      rd_en = 1'b0; en_capture = 1'b0;
      exp_cnt++;
      tests++; if ({rd_val, rd_valid, captured, changed} !== 4'b1111) begin
         fails++; $display("FAIL same_cycle_read: got %b expected 1111", {rd_val, rd_valid, captured, changed});
      end
      read(5'd4, 2'd0);
      tests++; if (rd_val !== 1'b0) begin
         fails++; $display("FAIL after_capture_read: got %b expected 0", rd_val);
      end
      read(5'd4, 2'd3);
      tests++; if (rd_val !== 1'b1) begin
         fails++; $display("FAIL after_capture_fall: got %b expected 1", rd_val);
      end
   endtask

   task automatic test_trigger();
      trg_mask = 32'h0000_00FF; trg_match = 32'h0000_003C; arm = 1'b1;
      tick();
      arm = 1'b0;
      capture(32'hFFFF_003D);
      tests++; if (trig !== 1'b0) begin
         fails++; $display("FAIL trg_nomatch: got %b expected 0", trig);
      end
      capture(32'h1234_563C);
      tests++; if (trig !== 1'b1) begin
         fails++; $display("FAIL trg_match: got %b expected 1", trig);
      end
      capture(32'h0000_0000);
      tests++; if (trig !== 1'b1) begin
         fails++; $display("FAIL trg_held: got %b expected 1", trig);
      end
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      tests++; if (trig !== 1'b0) begin
         fails++; $display("FAIL trg_disarm: got %b expected 0", trig);
      end
      // arm together with a capture of 0: new pattern (match 0) must be used
      in_data = 32'h0;
      tick();
      tick();
      trg_mask = 32'h0000_00FF; trg_match = 32'h0; arm = 1'b1; en_capture = 1'b1;
      tick();
      arm = 1'b0; en_capture = 1'b0;
      exp_cnt++;
      tests++; if (trig !== 1'b1) begin
         fails++; $display("FAIL trg_arm_capture: got %b expected 1", trig);
      end
      trg_match = 32'h0000_003C; arm = 1'b1;
      tick();
      arm = 1'b0;
      tests++; if (trig !== 1'b0) begin
         fails++; $display("FAIL trg_rearm: got %b expected 0", trig);
      end
      trg_mask = 32'h0; trg_match = 32'hFFFF_FFFF; arm = 1'b1;
      tick();
      arm = 1'b0;
      capture(32'h0000_0000);
      tests++; if (trig !== 1'b1) begin
         fails++; $display("FAIL trg_mask0: got %b expected 1", trig);
      end
   endtask

   task automatic test_arm_disarm_and_wrap();
      int n;
      disarm = 1'b1;
      tick();
      disarm = 1'b0;
      trg_mask = 32'h0000_00FF; trg_match = 32'h0; arm = 1'b1;
      tick();
      trg_mask = 32'h0; disarm = 1'b1;
      tick();
      arm = 1'b0; disarm = 1'b0;
      tests++; if (trig !== 1'b0) begin
         fails++; $display("FAIL arm_disarm: got %b expected 0", trig);
      end
      capture(32'h0000_0000);
      tests++; if (trig !== 1'b0) begin
         fails++; $display("FAIL arm_disarm_idle: got %b expected 0", trig);
      end
      n = 65535 - exp_cnt;
      en_capture = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      en_capture = 1'b0;
      exp_cnt = 65535;
      tests++; if (cap_count !== 16'hFFFF) begin
         fails++; $display("FAIL cnt_max: got %h expected ffff", cap_count);
      end
      capture(32'h0000_0000);
      tests++; if (cap_count !== 16'h0000) begin
         fails++; $display("FAIL cnt_wrap: got %h expected 0000", cap_count);
      end
   endtask

   task automatic test_async_reset();
      trg_mask = 32'h0; arm = 1'b1;
      tick();
      arm = 1'b0;
      capture(32'hFFFF_FFFF);
      read(5'd0, 2'd0);
      tests++; if ({trig, rd_val, changed} !== 3'b111) begin
         fails++; $display("FAIL pre_reset: got %b expected 111", {trig, rd_val, changed});
      end
      #2;
      reset = 1'b1;
      #1;
      tests++; if ({rd_val, rd_valid, captured, changed, trig} !== 5'b0) begin
         fails++; $display("FAIL async_reset_flags: got %b expected 00000", {rd_val, rd_valid, captured, changed, trig});
      end
      tests++; if (cap_count !== 16'h0) begin
         fails++; $display("FAIL async_reset_count: got %h expected 0000", cap_count);
      end
      tick();
      reset = 1'b0;
      read(5'd0, 2'd0);
      tests++; if ({rd_val, rd_valid} !== 2'b01) begin
         fails++; $display("FAIL post_reset_read: got %b expected 01", {rd_val, rd_valid});
      end
   endtask

   initial begin
      tests = 0; fails = 0; exp_cnt = 0;
      reset = 1'b1; in_data = '0; en_capture = 1'b0; rd_en = 1'b0; addr = '0; rd_sel = 2'd0;
      arm = 1'b0; disarm = 1'b0; trg_mask = '0; trg_match = '0;
      test_reset();
      test_basic_capture();
      test_edges();
      test_read_during_capture();
      test_trigger();
      test_arm_disarm_and_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
